stream_mux_rr: RTL

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_rr.sv | 107 ++++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// Registered stream multiplexer with fixed-select and round-robin arbitration.
// One output register holds each word. It accepts a new word in the same cycle the held one drains.
module stream_mux_rr #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   input  logic                      out_ready
);

   logic                outValid_q, outValid_d;
   logic [WIDTH-1:0]    outData_q, outData_d;
   logic [SEL_W-1:0]    outChan_q, outChan_d;
   logic [SEL_W-1:0]    ptr_q, ptr_d;

   logic                space;
   logic                grantValid;
   logic [SEL_W-1:0]    grantIdx;
   logic [SEL_W-1:0]    cand;
   logic [WIDTH-1:0]    grantData;
   logic                inFire;
   logic                outFire;

   assign space   = !outValid_q || out_ready;
   assign outFire = outValid_q && out_ready;

   // Search runs from the farthest candidate down to ptr+1, so the last hit is the nearest one
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      cand       = '0;
      if (!mode) begin
         if (int'(sel) < CHANNELS) begin
            grantValid = 1'b1;
            grantIdx   = sel;
         end
      end else begin
         for (int k = CHANNELS; k >= 1; k--) begin
            cand = SEL_W'((int'(ptr_q) + k) % CHANNELS);
            if (in_valid[cand]) begin
               grantValid = 1'b1;
               grantIdx   = cand;
            end
         end
      end
   end

   always_comb begin
      in_ready  = '0;
      grantData = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grantValid && (grantIdx == SEL_W'(i))) begin
            in_ready[i] = rst_n && space;
            grantData   = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign inFire = |(in_valid & in_ready);

   always_comb begin
      outValid_d = outValid_q;
      outData_d  = outData_q;
      outChan_d  = outChan_q;
      ptr_d      = ptr_q;
      if (inFire) begin
         outValid_d = 1'b1;
         outData_d  = grantData;
         outChan_d  = grantIdx;
         if (mode) begin
            ptr_d = grantIdx;
         end
      end else if (outFire) begin
         outValid_d = 1'b0;
      end
   end

   // The pointer starts on the last channel so that channel 0 wins first after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outChan_q  <= '0;
         ptr_q      <= SEL_W'(CHANNELS - 1);
      end else begin
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
         outChan_q  <= outChan_d;
         ptr_q      <= ptr_d;
      end
   end

   assign out_valid = outValid_q;
   assign out_data  = outData_q;
   assign out_chan  = outChan_q;

endmodule
